// File: rtl/busca_instrucao_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
// Single outstanding request; mem_ack completes it in one cycle.
interface busca_instrucao_if;
    localparam int unsigned LARGURA = 32;

    logic               mem_req;
    logic [LARGURA-1:0] mem_endereco;
    logic               mem_ack;
    logic [LARGURA-1:0] mem_dado;

    // Fetch stage side
    modport master (
        output mem_req,
        output mem_endereco,
        input  mem_ack,
        input  mem_dado
    );

    // Memory side
    modport slave (
        input  mem_req,
        input  mem_endereco,
        output mem_ack,
        output mem_dado
    );
endinterface

// File: rtl/busca_instrucao.sv
// Instruction fetch stage and IF/ID pipeline register.
// Keeps one request in flight, absorbs hazard stalls with a one-entry skid
// buffer and discards in-flight data on taken-branch redirects.
module busca_instrucao #(
    parameter logic [31:0] PC_INICIAL = 32'h0000_0000,
    parameter logic [31:0] NOP        = 32'h0000_0013
) (
    input  logic                     clock,
    input  logic                     reset_n,
    busca_instrucao_if.master        mem,
    input  logic                     Parada,
    input  logic                     DesvioTomado,
    input  logic [31:0]              AlvoDesvio,
    output logic [31:0]              Instrucao,
    output logic [31:0]              PCInstrucao,
    output logic                     InstrucaoValida,
    output logic [6:0]               CodigoDaOperacao
);

    localparam int unsigned LARGURA        = 32;
    localparam int unsigned LARGURA_OPCODE = 7;
    localparam logic [LARGURA-1:0] PASSO   = LARGURA'(4);
    localparam logic [LARGURA-1:0] MASCARA = ~LARGURA'(3);

    typedef enum logic [1:0] {
        REINICIO = 2'd0,
        BUSCA    = 2'd1,
        PARADO   = 2'd2,
        DESCARTE = 2'd3
    } tipoEstado;

    tipoEstado          estado;
    logic [LARGURA-1:0] pc;
    logic [LARGURA-1:0] endReq;
    logic [LARGURA-1:0] buffer;
    logic [LARGURA-1:0] bufferEnd;
    logic               bufferValido;
    logic               memReq;

    logic [LARGURA-1:0] alvo;
    logic [LARGURA-1:0] proximoEnd;

    // Redirect target is always word aligned; sequential address wraps mod 2^32
    assign alvo       = AlvoDesvio & MASCARA;
    assign proximoEnd = endReq + PASSO;

    // Request address is the in-flight address register, so it is stable until ack
    assign mem.mem_req      = memReq;
    assign mem.mem_endereco = endReq;

    // Opcode field feeds the main control decoder directly
    assign CodigoDaOperacao = Instrucao[LARGURA_OPCODE-1:0];

    // Fetch FSM, PC, skid buffer and IF/ID register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            estado          <= REINICIO;
            pc              <= PC_INICIAL;
            endReq          <= PC_INICIAL;
            buffer          <= NOP;
            bufferEnd       <= '0;
            bufferValido    <= 1'b0;
            memReq          <= 1'b0;
            Instrucao       <= NOP;
            PCInstrucao     <= '0;
            InstrucaoValida <= 1'b0;
        end else begin
            case (estado)
                REINICIO: begin
                    endReq <= pc;
                    memReq <= 1'b1;
                    estado <= BUSCA;
                end

                BUSCA: begin
                    if (DesvioTomado) begin
                        // Redirect wins: flush IF/ID, drop any arriving data
                        Instrucao       <= NOP;
                        InstrucaoValida <= 1'b0;
                        pc              <= alvo;
                        if (mem.mem_ack) begin
                            endReq <= alvo;
                        end else begin
                            // Old request must still complete at its own address
                            estado <= DESCARTE;
                        end
                    end else if (mem.mem_ack) begin
                        if (!Parada || !InstrucaoValida) begin
                            Instrucao       <= mem.mem_dado;
                            PCInstrucao     <= endReq;
                            InstrucaoValida <= 1'b1;
                            pc              <= proximoEnd;
                            endReq          <= proximoEnd;
                        end else begin
                            // IF/ID is occupied and held: park the word in the skid buffer
                            buffer       <= mem.mem_dado;
                            bufferEnd    <= endReq;
                            bufferValido <= 1'b1;
                            pc           <= proximoEnd;
                            memReq       <= 1'b0;
                            estado       <= PARADO;
                        end
                    end else if (!Parada) begin
                        // Memory still busy and decode is consuming: insert a bubble
                        Instrucao       <= NOP;
                        InstrucaoValida <= 1'b0;
                    end
                end

                PARADO: begin
                    if (DesvioTomado) begin
                        Instrucao       <= NOP;
                        InstrucaoValida <= 1'b0;
                        bufferValido    <= 1'b0;
                        pc              <= alvo;
                        endReq          <= alvo;
                        memReq          <= 1'b1;
                        estado          <= BUSCA;
                    end else if (!Parada) begin
                        Instrucao       <= buffer;
                        PCInstrucao     <= bufferEnd;
                        InstrucaoValida <= bufferValido;
                        bufferValido    <= 1'b0;
                        endReq          <= pc;
                        memReq          <= 1'b1;
                        estado          <= BUSCA;
                    end
                end

                DESCARTE: begin
                    // IF/ID stays empty until the redirected stream arrives
                    Instrucao       <= NOP;
                    InstrucaoValida <= 1'b0;
                    if (DesvioTomado) begin
                        pc <= alvo;
                    end
                    if (mem.mem_ack) begin
                        endReq <= DesvioTomado ? alvo : pc;
                        estado <= BUSCA;
                    end
                end

                default: begin
                    memReq <= 1'b0;
                    estado <= REINICIO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_busca_instrucao.sv
// Self-checking bench for busca_instrucao: directed scenarios plus a
// randomized run checked against a program-order stream model.
module tb_busca_instrucao;

    localparam logic [31:0] NOP_W = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        Parada;
    logic        DesvioTomado;
    logic [31:0] AlvoDesvio;
    logic [31:0] Instrucao;
    logic [31:0] PCInstrucao;
    logic        InstrucaoValida;
    logic [6:0]  CodigoDaOperacao;

    logic [31:0] Instrucao2;
    logic [31:0] PCInstrucao2;
    logic        InstrucaoValida2;
    logic [6:0]  CodigoDaOperacao2;

    int errors = 0;
    int checks = 0;
    int latencia = 0;
    int waitCnt = 0;

    busca_instrucao_if busIf ();
    busca_instrucao_if busIf2 ();

    busca_instrucao dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .mem              (busIf),
        .Parada           (Parada),
        .DesvioTomado     (DesvioTomado),
        .AlvoDesvio       (AlvoDesvio),
        .Instrucao        (Instrucao),
        .PCInstrucao      (PCInstrucao),
        .InstrucaoValida  (InstrucaoValida),
        .CodigoDaOperacao (CodigoDaOperacao)
    );

    busca_instrucao #(.PC_INICIAL(32'hFFFF_FFFC)) dut2 (
        .clock            (clock),
        .reset_n          (reset_n),
        .mem              (busIf2),
        .Parada           (1'b0),
        .DesvioTomado     (1'b0),
        .AlvoDesvio       (32'h0),
        .Instrucao        (Instrucao2),
        .PCInstrucao      (PCInstrucao2),
        .InstrucaoValida  (InstrucaoValida2),
        .CodigoDaOperacao (CodigoDaOperacao2)
    );

    always #5 clock = ~clock;

    // Memory model: word at an address equals the address; ack after latencia idle cycles
    assign busIf.mem_ack  = busIf.mem_req && (waitCnt >= latencia);
    assign busIf.mem_dado = busIf.mem_endereco;
    assign busIf2.mem_ack  = busIf2.mem_req;
    assign busIf2.mem_dado = busIf2.mem_endereco;

    always @(posedge clock) begin
        if (!busIf.mem_req || busIf.mem_ack) waitCnt <= 0;
        else waitCnt <= waitCnt + 1;
    end

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; Parada = 1'b0; DesvioTomado = 1'b0; AlvoDesvio = 32'h0;
        step();
        step();
        checks++; if (busIf.mem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", busIf.mem_req); end
        checks++; if (InstrucaoValida !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", InstrucaoValida); end
        checks++; if (Instrucao !== NOP_W) begin errors++; $display("FAIL rst_instr: got %h expected %h", Instrucao, NOP_W); end
        checks++; if (PCInstrucao !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected 0", PCInstrucao); end
        checks++; if (CodigoDaOperacao !== 7'h13) begin errors++; $display("FAIL rst_opcode: got %h expected 13", CodigoDaOperacao); end
        checks++; if (busIf2.mem_req !== 1'b0) begin errors++; $display("FAIL rst_req2: got %b expected 0", busIf2.mem_req); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] a;
        latencia = 0;
        doReset();
        checks++; if (busIf.mem_req !== 1'b1 || busIf.mem_endereco !== 32'h0) begin errors++; $display("FAIL zw_first_req: got req=%b addr=%h expected req=1 addr=0", busIf.mem_req, busIf.mem_endereco); end
        checks++; if (InstrucaoValida !== 1'b0) begin errors++; $display("FAIL zw_first_valid: got %b expected 0", InstrucaoValida); end
        for (int k = 0; k < 8; k++) begin
            step();
            a = 32'(4 * k);
            checks++; if (PCInstrucao !== a || Instrucao !== a || InstrucaoValida !== 1'b1) begin errors++; $display("FAIL zw_ifid[%0d]: got pc=%h instr=%h v=%b expected pc=%h instr=%h v=1", k, PCInstrucao, Instrucao, InstrucaoValida, a, a); end
            checks++; if (CodigoDaOperacao !== a[6:0]) begin errors++; $display("FAIL zw_opcode[%0d]: got %h expected %h", k, CodigoDaOperacao, a[6:0]); end
            checks++; if (busIf.mem_endereco !== a + 32'd4) begin errors++; $display("FAIL zw_addr[%0d]: got %h expected %h", k, busIf.mem_endereco, a + 32'd4); end
        end
    endtask

    task automatic test_stall();
        latencia = 0;
        doReset();
        for (int i = 0; i < 4; i++) step();
        checks++; if (PCInstrucao !== 32'hC || busIf.mem_endereco !== 32'h10) begin errors++; $display("FAIL st_pre: got pc=%h addr=%h expected pc=c addr=10", PCInstrucao, busIf.mem_endereco); end
        Parada = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (PCInstrucao !== 32'hC || Instrucao !== 32'hC || InstrucaoValida !== 1'b1 || busIf.mem_req !== 1'b0) begin errors++; $display("FAIL st_hold[%0d]: got pc=%h instr=%h v=%b req=%b expected pc=c instr=c v=1 req=0", i, PCInstrucao, Instrucao, InstrucaoValida, busIf.mem_req); end
        end
        Parada = 1'b0;
        step();
        checks++; if (PCInstrucao !== 32'h10 || Instrucao !== 32'h10 || InstrucaoValida !== 1'b1) begin errors++; $display("FAIL st_release: got pc=%h instr=%h v=%b expected pc=10 instr=10 v=1", PCInstrucao, Instrucao, InstrucaoValida); end
        checks++; if (busIf.mem_req !== 1'b1 || busIf.mem_endereco !== 32'h14) begin errors++; $display("FAIL st_refetch: got req=%b addr=%h expected req=1 addr=14", busIf.mem_req, busIf.mem_endereco); end
        step();
        checks++; if (PCInstrucao !== 32'h14 || InstrucaoValida !== 1'b1 || busIf.mem_endereco !== 32'h18) begin errors++; $display("FAIL st_next: got pc=%h v=%b addr=%h expected pc=14 v=1 addr=18", PCInstrucao, InstrucaoValida, busIf.mem_endereco); end
    endtask

    task automatic test_redirect_latency();
        latencia = 2;
        doReset();
        for (int i = 0; i < 60 && busIf.mem_endereco !== 32'h20; i++) step();
        checks++; if (busIf.mem_endereco !== 32'h20 || busIf.mem_ack !== 1'b0) begin errors++; $display("FAIL rl_reach: got addr=%h ack=%b expected addr=20 ack=0", busIf.mem_endereco, busIf.mem_ack); end
        DesvioTomado = 1'b1; AlvoDesvio = 32'h100;
        step();
        DesvioTomado = 1'b0;
        checks++; if (busIf.mem_req !== 1'b1 || busIf.mem_endereco !== 32'h20 || busIf.mem_ack !== 1'b0) begin errors++; $display("FAIL rl_hold1: got req=%b addr=%h ack=%b expected req=1 addr=20 ack=0", busIf.mem_req, busIf.mem_endereco, busIf.mem_ack); end
        checks++; if (InstrucaoValida !== 1'b0 || Instrucao !== NOP_W) begin errors++; $display("FAIL rl_flush: got v=%b instr=%h expected v=0 instr=%h", InstrucaoValida, Instrucao, NOP_W); end
        step();
        checks++; if (busIf.mem_endereco !== 32'h20 || busIf.mem_ack !== 1'b1 || InstrucaoValida !== 1'b0) begin errors++; $display("FAIL rl_hold2: got addr=%h ack=%b v=%b expected addr=20 ack=1 v=0", busIf.mem_endereco, busIf.mem_ack, InstrucaoValida); end
        step();
        for (int i = 0; i < 3; i++) begin
            checks++; if (busIf.mem_endereco !== 32'h100 || busIf.mem_req !== 1'b1 || InstrucaoValida !== 1'b0) begin errors++; $display("FAIL rl_wait[%0d]: got addr=%h req=%b v=%b expected addr=100 req=1 v=0", i, busIf.mem_endereco, busIf.mem_req, InstrucaoValida); end
            step();
        end
        checks++; if (PCInstrucao !== 32'h100 || Instrucao !== 32'h100 || InstrucaoValida !== 1'b1) begin errors++; $display("FAIL rl_target: got pc=%h instr=%h v=%b expected pc=100 instr=100 v=1", PCInstrucao, Instrucao, InstrucaoValida); end
    endtask

    task automatic test_redirect_ack();
        latencia = 0;
        doReset();
        for (int i = 0; i < 3; i++) step();
        DesvioTomado = 1'b1; AlvoDesvio = 32'h203;
        step();
        DesvioTomado = 1'b0;
        checks++; if (busIf.mem_req !== 1'b1 || busIf.mem_endereco !== 32'h200) begin errors++; $display("FAIL ra_addr: got req=%b addr=%h expected req=1 addr=200", busIf.mem_req, busIf.mem_endereco); end
        checks++; if (InstrucaoValida !== 1'b0 || Instrucao !== NOP_W || CodigoDaOperacao !== 7'h13) begin errors++; $display("FAIL ra_flush: got v=%b instr=%h op=%h expected v=0 instr=%h op=13", InstrucaoValida, Instrucao, CodigoDaOperacao, NOP_W); end
        step();
        checks++; if (PCInstrucao !== 32'h200 || Instrucao !== 32'h200 || InstrucaoValida !== 1'b1 || busIf.mem_endereco !== 32'h204) begin errors++; $display("FAIL ra_target: got pc=%h instr=%h v=%b addr=%h expected pc=200 instr=200 v=1 addr=204", PCInstrucao, Instrucao, InstrucaoValida, busIf.mem_endereco); end
    endtask

    task automatic test_reset_mid();
        latencia = 3;
        doReset();
        for (int i = 0; i < 20 && InstrucaoValida !== 1'b1; i++) step();
        Parada = 1'b1;
        step();
        checks++; if (busIf.mem_req !== 1'b1 || InstrucaoValida !== 1'b1 || PCInstrucao !== 32'h0) begin errors++; $display("FAIL rm_pre: got req=%b v=%b pc=%h expected req=1 v=1 pc=0", busIf.mem_req, InstrucaoValida, PCInstrucao); end
        reset_n = 1'b0;
        step();
        checks++; if (busIf.mem_req !== 1'b0 || InstrucaoValida !== 1'b0 || Instrucao !== NOP_W) begin errors++; $display("FAIL rm_reset: got req=%b v=%b instr=%h expected req=0 v=0 instr=%h", busIf.mem_req, InstrucaoValida, Instrucao, NOP_W); end
        Parada = 1'b0; latencia = 0; reset_n = 1'b1;
        step();
        checks++; if (busIf.mem_req !== 1'b1 || busIf.mem_endereco !== 32'h0) begin errors++; $display("FAIL rm_restart: got req=%b addr=%h expected req=1 addr=0", busIf.mem_req, busIf.mem_endereco); end
        step();
        checks++; if (PCInstrucao !== 32'h0 || InstrucaoValida !== 1'b1) begin errors++; $display("FAIL rm_first: got pc=%h v=%b expected pc=0 v=1", PCInstrucao, InstrucaoValida); end
    endtask

    task automatic test_wrap();
        doReset();
        checks++; if (busIf2.mem_req !== 1'b1 || busIf2.mem_endereco !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_first: got req=%b addr=%h expected req=1 addr=fffffffc", busIf2.mem_req, busIf2.mem_endereco); end
        step();
        checks++; if (PCInstrucao2 !== 32'hFFFF_FFFC || InstrucaoValida2 !== 1'b1 || CodigoDaOperacao2 !== 7'h7C) begin errors++; $display("FAIL wr_ifid: got pc=%h v=%b op=%h expected pc=fffffffc v=1 op=7c", PCInstrucao2, InstrucaoValida2, CodigoDaOperacao2); end
        checks++; if (busIf2.mem_endereco !== 32'h0) begin errors++; $display("FAIL wr_second: got addr=%h expected 0", busIf2.mem_endereco); end
        step();
        checks++; if (PCInstrucao2 !== 32'h0 || Instrucao2 !== 32'h0 || busIf2.mem_endereco !== 32'h4) begin errors++; $display("FAIL wr_after: got pc=%h instr=%h addr=%h expected pc=0 instr=0 addr=4", PCInstrucao2, Instrucao2, busIf2.mem_endereco); end
    endtask

    // Stream model: deliveries must follow program order from the last redirect target
    task automatic test_random();
        logic [31:0] expNext, prevInstr, prevPc, prevAddr, alvoSel;
        logic        prevValid, prevReq, prevAck, p, d;
        int          entregas;
        entregas = 0;
        latencia = 0;
        doReset();
        expNext = 32'h0;
        for (int c = 0; c < 1500; c++) begin
            if (c % 25 == 0) latencia = $urandom_range(0, 3);
            p = ($urandom_range(0, 99) < 35);
            d = ($urandom_range(0, 99) < 6);
            alvoSel = $urandom;
            Parada = p; DesvioTomado = d; AlvoDesvio = alvoSel;
            #1;
            prevValid = InstrucaoValida; prevInstr = Instrucao; prevPc = PCInstrucao;
            prevReq = busIf.mem_req; prevAck = busIf.mem_ack; prevAddr = busIf.mem_endereco;
            step();
            Parada = 1'b0; DesvioTomado = 1'b0;
            checks++; if (CodigoDaOperacao !== Instrucao[6:0]) begin errors++; $display("FAIL rnd_opcode[%0d]: got %h expected %h", c, CodigoDaOperacao, Instrucao[6:0]); end
            if (prevReq && !prevAck) begin
                checks++; if (busIf.mem_req !== 1'b1 || busIf.mem_endereco !== prevAddr) begin errors++; $display("FAIL rnd_req_stable[%0d]: got req=%b addr=%h expected req=1 addr=%h", c, busIf.mem_req, busIf.mem_endereco, prevAddr); end
            end
            if (d) begin
                checks++; if (InstrucaoValida !== 1'b0 || Instrucao !== NOP_W) begin errors++; $display("FAIL rnd_flush[%0d]: got v=%b instr=%h expected v=0 instr=%h", c, InstrucaoValida, Instrucao, NOP_W); end
                expNext = alvoSel & ~32'h3;
            end else if (prevValid && p) begin
                checks++; if (InstrucaoValida !== 1'b1 || Instrucao !== prevInstr || PCInstrucao !== prevPc) begin errors++; $display("FAIL rnd_hold[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h", c, InstrucaoValida, PCInstrucao, Instrucao, prevPc, prevInstr); end
            end else if (InstrucaoValida === 1'b1) begin
                checks++; if (PCInstrucao !== expNext || Instrucao !== expNext) begin errors++; $display("FAIL rnd_order[%0d]: got pc=%h instr=%h expected pc=%h instr=%h", c, PCInstrucao, Instrucao, expNext, expNext); end
                expNext = expNext + 32'd4;
                entregas++;
            end else begin
                checks++; if (Instrucao !== NOP_W) begin errors++; $display("FAIL rnd_bubble[%0d]: got instr=%h expected %h", c, Instrucao, NOP_W); end
            end
        end
        checks++; if (entregas < 50) begin errors++; $display("FAIL rnd_progress: got %0d deliveries expected at least 50", entregas); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall();
        test_redirect_latency();
        test_redirect_ack();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
